mux3_arbiter: RTL and testbench

Shares a single 32-bit output channel between three packet-based requesters, using one `mux3_32` instance for the datapath. The arbiter grants one requester per packet, holds the grant until the packet ends, and drives the mux select. It sits between three producer blocks and one downstream consumer, with a valid/ready handshake on every side.

---
 rtl/mux3_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mux3_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux3_arbiter.sv
// mux3_arbiter: shares one 32-bit valid/ready output channel between three
// packet-based requesters. One grant lasts one packet, or MAX_BEATS beats at most.
// The three requesters are muxed onto the output by a mux3_32 instance.
// Build option: define MUX3_ARB_RR_EN for round-robin arbitration starting at
// ptr. Without it, arbitration is fixed priority (0 > 1 > 2).

// Three-way 32-bit mux. A select value of 3 drives all zeros.
module mux3_32 (
  input  logic [95:0] a,
  input  logic [1:0]  s,
  output logic [31:0] y
);

  // Select one 32-bit lane of the packed input.
  always_comb begin
    y = 32'h0;
    case (s)
      2'd0:    y = a[31:0];
      2'd1:    y = a[63:32];
      2'd2:    y = a[95:64];
      default: y = 32'h0;
    endcase
  end

endmodule

module mux3_arbiter #(
  parameter int MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  in_valid,
  output logic [2:0]  in_ready,
  input  logic [95:0] in_data,
  input  logic [2:0]  in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [1:0]  sel,
  output logic        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       busy_q, busy_d;

  logic [1:0] winner;
  logic       owner_valid;
  logic       owner_last;
  logic       granted;
  logic       accept;

  assign granted = (state_q == GRANT);

`ifdef MUX3_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand_idx [3];
  logic [2:0] rot_valid;

  // Candidate gi is the requester at offset gi from ptr, modulo 3.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rr
    logic [2:0] sum;
    assign sum           = {1'b0, ptr_q} + 3'(gi);
    assign cand_idx[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign rot_valid[gi] = |(in_valid & (3'b001 << cand_idx[gi]));
  end

  // The first requesting candidate, counting from ptr, wins.
  always_comb begin
    winner = 2'd3;
    if (rot_valid[2]) winner = cand_idx[2];
    if (rot_valid[1]) winner = cand_idx[1];
    if (rot_valid[0]) winner = cand_idx[0];
  end
`else
  // Fixed priority: the lowest-numbered requester wins.
  always_comb begin
    winner = 2'd3;
    if (in_valid[2]) winner = 2'd2;
    if (in_valid[1]) winner = 2'd1;
    if (in_valid[0]) winner = 2'd0;
  end
`endif

  // Pick out the owner's valid and last. Both are forced low when no grant is held.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    if (granted) begin
      case (sel_q)
        2'd0: begin owner_valid = in_valid[0]; owner_last = in_last[0]; end
        2'd1: begin owner_valid = in_valid[1]; owner_last = in_last[1]; end
        2'd2: begin owner_valid = in_valid[2]; owner_last = in_last[2]; end
        default: begin owner_valid = 1'b0; owner_last = 1'b0; end
      endcase
    end
  end

  // Only the owner sees downstream ready. Every other requester is held off.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ready
    assign in_ready[gi] = granted && (sel_q == 2'(gi)) && out_ready;
  end

  assign out_valid = owner_valid;
  assign out_last  = granted && (owner_last || (beat_cnt_q == LAST_CNT));
  assign accept    = out_valid && out_ready;
  assign sel       = sel_q;
  assign busy      = busy_q;

  mux3_32 u_mux (
    .a (in_data),
    .s (sel_q),
    .y (out_data)
  );

  // Next-state logic: grant on any request, release on an accepted last beat.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
`ifdef MUX3_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          state_d    = GRANT;
          sel_d      = winner;
          beat_cnt_d = 8'd0;
          busy_d     = 1'b1;
        end
      end
      GRANT: begin
        if (accept) begin
          if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
          if (out_last) begin
            state_d = IDLE;
            sel_d   = 2'd3;
            busy_d  = 1'b0;
`ifdef MUX3_ARB_RR_EN
            ptr_d   = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs. An asynchronous reset drops any partial packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= 2'd3;
      beat_cnt_q <= 8'd0;
      busy_q     <= 1'b0;
`ifdef MUX3_ARB_RR_EN
      ptr_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
`ifdef MUX3_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux3_arbiter.sv
// tb_mux3_arbiter: randomized scoreboard bench for mux3_arbiter (MAX_BEATS = 4).
// Producers hold per-requester beat queues. A transaction-level model predicts
// each grant and pushes the expected beats. A monitor pops and compares them on
// every accepted output beat.
`timescale 1ns/1ps
module tb_mux3_arbiter;

  localparam int MB = 4;

  typedef struct packed {
    logic [1:0]  req;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid = 3'b000;
  logic [2:0]  in_ready;
  logic [95:0] in_data = '0;
  logic [2:0]  in_last = 3'b000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [1:0]  sel;
  logic        busy;

  int    vectors = 0;
  int    errors = 0;
  int    valid_pct = 100;
  int    ready_pct = 100;
  bit    drv_en = 1'b0;
  logic [2:0] acc_vec = 3'b000;
  int    acc_total = 0;

  beat_t pq [3][$];
  beat_t mq [3][$];
  beat_t exp_q [$];
  int    dut_grants [$];
  logic [1:0] prev_sel = 2'd3;

  int    model_owner = 3;
  int    model_left = 0;
  int    model_ptr = 0;
  bit    model_closed = 1'b0;
  int    mw, mn;
  beat_t mb, mon_b, drv_b, drop_b;

  mux3_arbiter #(.MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int n, input logic [31:0] base, input bit term);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.req  = 2'(r);
      b.data = base + 32'(k);
      b.last = term && (k == n - 1);
      pq[r].push_back(b);
      mq[r].push_back(b);
    end
  endtask

  // Arbitration rule: the first requester found by searching from ptr (round-robin) or from 0.
  function automatic int pick(input logic [2:0] v, input int p);
`ifdef MUX3_ARB_RR_EN
    for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (v[k]) return k;
`endif
    return 3;
  endfunction

  // Reference model. A grant covers up to MB beats and ends early on the packet's last beat.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_owner = 3; model_left = 0; model_ptr = 0; model_closed = 1'b0;
    end else if (model_owner == 3) begin
      if (|in_valid) begin
        mw = pick(in_valid, model_ptr);
        mn = 0;
        model_closed = 1'b0;
        while (!model_closed && mn < MB && mq[mw].size() > 0) begin
          mb = mq[mw].pop_front();
          if (mn == MB - 1) mb.last = 1'b1;
          exp_q.push_back(mb);
          mn++;
          if (mb.last) model_closed = 1'b1;
        end
        model_owner = mw;
        model_left  = mn;
      end
    end else if (in_valid[model_owner] && out_ready) begin
      if (model_left > 0) model_left--;
      if (model_left == 0 && model_closed) begin
        model_ptr   = (model_owner + 1) % 3;
        model_owner = 3;
      end
    end
  end

  // Producers: retire accepted beats, then present the next head beat (valid is randomly gated).
  always @(posedge clk) begin
    if (drv_en) begin
      for (int i = 0; i < 3; i++)
        if (acc_vec[i] && pq[i].size() > 0) drop_b = pq[i].pop_front();
      #1;
      for (int i = 0; i < 3; i++) begin
        if (pq[i].size() > 0 && int'($urandom_range(99)) < valid_pct) begin
          drv_b = pq[i][0];
          in_valid[i] = 1'b1;
          in_data[32*i +: 32] = drv_b.data;
          in_last[i] = drv_b.last;
        end else begin
          in_valid[i] = 1'b0;
          in_data[32*i +: 32] = $urandom;
          in_last[i] = 1'($urandom);
        end
      end
      out_ready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  // Monitor: check the combinational channel every cycle and score each accepted beat.
  always @(negedge clk) begin
    chk("sel", 32'(sel), 32'(model_owner));
    chk("busy", 32'(busy), 32'(model_owner != 3));
    if (model_owner != 3) begin
      chk("out_valid", 32'(out_valid), 32'(in_valid[model_owner]));
      chk("in_ready", 32'(in_ready), out_ready ? 32'(1 << model_owner) : 32'd0);
      chk("out_data_path", out_data, in_data[32*model_owner +: 32]);
    end else begin
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_out_data", out_data, 32'd0);
      chk("idle_out_last", 32'(out_last), 32'd0);
    end
    acc_vec = in_valid & in_ready;
    if (out_valid && out_ready) begin
      acc_total++;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL beat: got unexpected beat 0x%0h from req %0d, required none", out_data, sel);
      end else begin
        mon_b = exp_q.pop_front();
        chk("beat_data", out_data, mon_b.data);
        chk("beat_last", 32'(out_last), 32'(mon_b.last));
        chk("beat_req", 32'(sel), 32'(mon_b.req));
        $display("beat req=%0d data=0x%08h last=%0b", sel, out_data, out_last);
      end
    end
    if (sel != 2'd3 && prev_sel == 2'd3) dut_grants.push_back(int'(sel));
    prev_sel = sel;
  end

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!(pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
             exp_q.size() == 0 && model_owner == 3) && c < budget) begin
      @(negedge clk); #1; c++;
    end
    chk("drain_timeout", 32'(c >= budget), 32'd0);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int c = 0;
    while (acc_total < target && c < budget) begin
      @(negedge clk); #1; c++;
    end
    chk("beats_reached", 32'(acc_total), 32'(target));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 32'd3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin pq[i].delete(); mq[i].delete(); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int eg [4];
  int g0, base;

  initial begin
`ifdef MUX3_ARB_RR_EN
    eg = '{0, 1, 2, 0};
`else
    eg = '{0, 0, 0, 1};
`endif
    // Reset with random inputs.
    #1 rst = 1'b0;
    in_valid  = 3'($urandom);
    in_data   = {$urandom, $urandom, $urandom};
    in_last   = 3'($urandom);
    out_ready = 1'($urandom);
    #2;
    chk("reset_sel", 32'(sel), 32'd3);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 3'b000; in_last = 3'b000; out_ready = 1'b0;
    drv_en = 1'b1;

    // Contention: all three requesters, three 2-beat packets each.
    dut_grants.delete();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 3; p++) add_pkt(r, 2, 32'h100 * 32'(r + 1) + 32'(p * 16), 1'b1);
    wait_idle(400);
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant_order%0d", k), (k < dut_grants.size()) ? 32'(dut_grants[k]) : 32'd99, 32'(eg[k]));

    // Single packet from requester 1.
    add_pkt(1, 3, 32'hA1, 1'b1);
    wait_idle(100);

    // Random traffic with backpressure and valid gaps.
    valid_pct = 70; ready_pct = 60;
    for (int p = 0; p < 15; p++) add_pkt(int'($urandom_range(2)), int'($urandom_range(6, 1)), $urandom, 1'b1);
    wait_idle(3000);
    valid_pct = 100; ready_pct = 100;

    // Forced release: 6 beats with no last produce two grants of 4 and 2 beats.
    g0 = dut_grants.size();
    base = acc_total;
    add_pkt(2, 6, 32'hF0, 1'b0);
    wait_acc(base + 6, 100);
    chk("forced_grants", 32'(dut_grants.size() - g0), 32'd2);
    apply_reset();

    // Reset mid-packet, then check that arbitration restarts from ptr 0.
    add_pkt(0, 1, 32'hB0, 1'b1);
    wait_idle(50);
    base = acc_total;
    add_pkt(1, 5, 32'hC0, 1'b1);
    wait_acc(base + 2, 50);
    apply_reset();
    dut_grants.delete();
    for (int r = 0; r < 3; r++) add_pkt(r, 1, 32'hD0 + 32'(r), 1'b1);
    wait_idle(100);
    chk("post_reset_grant", (dut_grants.size() > 0) ? 32'(dut_grants[0]) : 32'd99, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
